// File: rtl/counter_sequencer_pkg.sv
// Shared types and constants for the counter sequencer: FSM state encoding
// and the run-mode selector values.
package counter_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } seqState_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/syn_up_counter_ce.sv
// N-bit up-counter with synchronous clear (dominant) and count enable.
module syn_up_counter_ce #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         en,
   output logic [N-1:0] Q
);

   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         Q <= '0;
      end else if (clr) begin
         Q <= '0;
      end else if (en) begin
         Q <= Q + ONE;
      end
   end

endmodule

// File: rtl/counter_sequencer.sv
// Timer/sequencer: prescaler, command FSM and terminal-count compare wrapped
// around a clear/enable up-counter whose value is exported as Q.
module counter_sequencer
   import counter_sequencer_pkg::*;
#(
   parameter int N          = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  pause,
   input  logic                  mode,
   input  logic [N-1:0]          limit,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [N-1:0]          Q,
   output logic                  busy,
   output logic                  done
);

   localparam logic [PRESCALE_W-1:0] PRE_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

   seqState_t             state_q;
   logic                  mode_q;
   logic [N-1:0]          limit_q;
   logic [PRESCALE_W-1:0] prescale_q;
   logic [PRESCALE_W-1:0] preCnt_q;
   logic                  busy_q;
   logic                  done_q;

   logic tick;
   logic terminal;
   logic runAdvance;
   logic cntClr;
   logic cntEn;

   // A tick only counts when RUN is neither aborted nor paused on that edge.
   always_comb begin
      runAdvance = (state_q == RUN) && !stop && !pause;
      tick       = (preCnt_q == prescale_q);
      terminal   = tick && (Q == limit_q);
      cntClr     = (stop && (state_q != IDLE))
                 || (start && ((state_q == IDLE) || (state_q == DONE)))
                 || (runAdvance && terminal && (mode_q == MODE_PERIODIC));
      cntEn      = runAdvance && tick && !terminal;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         mode_q     <= MODE_ONESHOT;
         limit_q    <= '0;
         prescale_q <= '0;
         preCnt_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q    <= RUN;
                  mode_q     <= mode;
                  limit_q    <= limit;
                  prescale_q <= prescale;
                  preCnt_q   <= '0;
                  busy_q     <= 1'b1;
               end
            end
            RUN: begin
               if (stop) begin
                  state_q  <= IDLE;
                  preCnt_q <= '0;
                  busy_q   <= 1'b0;
               end else if (pause) begin
                  state_q <= PAUSE;
               end else if (tick) begin
                  preCnt_q <= '0;
                  if (terminal) begin
                     done_q <= 1'b1;
                     if (mode_q == MODE_ONESHOT) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                     end
                  end
               end else begin
                  preCnt_q <= preCnt_q + PRE_ONE;
               end
            end
            PAUSE: begin
               if (stop) begin
                  state_q  <= IDLE;
                  preCnt_q <= '0;
                  busy_q   <= 1'b0;
               end else if (start) begin
                  state_q <= RUN;
               end
            end
            DONE: begin
               if (stop) begin
                  state_q <= IDLE;
               end else if (start) begin
                  state_q    <= RUN;
                  mode_q     <= mode;
                  limit_q    <= limit;
                  prescale_q <= prescale;
                  preCnt_q   <= '0;
                  busy_q     <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   syn_up_counter_ce #(
      .N(N)
   ) u_counter (
      .clk    (clk),
      .reset_n(reset_n),
      .clr    (cntClr),
      .en     (cntEn),
      .Q      (Q)
   );

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: fixed vector table, directed
// corner sequences and randomized commands against a position-based model.
module tb_counter_sequencer;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic       stop;
   logic       pause;
   logic       mode;
   logic [7:0] limit;
   logic [3:0] prescale;
   logic [7:0] Q;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   counter_sequencer #(
      .N(8),
      .PRESCALE_W(4)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .stop    (stop),
      .pause   (pause),
      .mode    (mode),
      .limit   (limit),
      .prescale(prescale),
      .Q       (Q),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The model tracks the clock position within the current period; Q and
   // terminal events are derived from it with plain arithmetic.
   bit mActive, mPaused, mFinished, mMode, mDone;
   int mPos, mLim, mPre;

   function automatic void modelReset();
      mActive = 0; mPaused = 0; mFinished = 0; mMode = 0; mDone = 0;
      mPos = 0; mLim = 0; mPre = 0;
   endfunction

   function automatic int modelQ();
      if (mActive) return mPos / (mPre + 1);
      if (mFinished) return mLim;
      return 0;
   endfunction

   function automatic void modelStep(bit st, bit sp, bit pa, bit md, int lim, int pre);
      mDone = 0;
      if (mActive && !mPaused) begin
         if (sp) begin
            mActive = 0; mPos = 0;
         end else if (pa) begin
            mPaused = 1;
         end else if (mPos == (mLim + 1) * (mPre + 1) - 1) begin
            mDone = 1;
            if (mMode) mPos = 0;
            else begin
               mActive = 0; mFinished = 1;
            end
         end else begin
            mPos++;
         end
      end else if (mActive) begin
         if (sp) begin
            mActive = 0; mPaused = 0; mPos = 0;
         end else if (st) begin
            mPaused = 0;
         end
      end else if (mFinished && sp) begin
         mFinished = 0;
      end else if (st) begin
         mActive = 1; mPaused = 0; mFinished = 0;
         mMode = md; mLim = lim; mPre = pre; mPos = 0;
      end
   endfunction

   task automatic applyStimulus(input bit st, input bit sp, input bit pa, input bit md,
                                input logic [7:0] lim, input logic [3:0] pre);
      start = st; stop = sp; pause = pa; mode = md; limit = lim; prescale = pre;
      @(posedge clk);
      modelStep(st, sp, pa, md, int'(lim), int'(pre));
      #1;
      start = 1'b0; stop = 1'b0; pause = 1'b0;
   endtask

   task automatic checkOutput(input string name, input int eQ, input bit eB, input bit eD);
      checks++;
      if (int'(Q) != eQ || busy !== eB || done !== eD) begin
         errors++;
         $display("[TB] FAIL %s: got Q=%0d busy=%0b done=%0b, expected Q=%0d busy=%0b done=%0b",
                  name, Q, busy, done, eQ, eB, eD);
      end
   endtask

   task automatic checkModel(input string name);
      checkOutput(name, modelQ(), mActive, mDone);
   endtask

   typedef struct {
      bit         st, sp, pa, md;
      logic [7:0] lim;
      logic [3:0] pre;
      int         eQ;
      bit         eB, eD;
   } vec_t;

   vec_t vecs[15];

   initial begin
      int doneCount;
      bit reached;

      vecs[0]  = '{1, 0, 0, 0, 8'd3, 4'd0, 0, 1, 0};
      vecs[1]  = '{0, 0, 0, 0, 8'd3, 4'd0, 1, 1, 0};
      vecs[2]  = '{0, 0, 0, 0, 8'd3, 4'd0, 2, 1, 0};
      vecs[3]  = '{0, 0, 0, 0, 8'd3, 4'd0, 3, 1, 0};
      vecs[4]  = '{0, 0, 0, 0, 8'd3, 4'd0, 3, 0, 1};
      vecs[5]  = '{0, 0, 0, 0, 8'd3, 4'd0, 3, 0, 0};
      vecs[6]  = '{1, 0, 0, 1, 8'd1, 4'd0, 0, 1, 0};
      vecs[7]  = '{0, 0, 0, 1, 8'd1, 4'd0, 1, 1, 0};
      vecs[8]  = '{0, 0, 0, 1, 8'd1, 4'd0, 0, 1, 1};
      vecs[9]  = '{1, 1, 0, 1, 8'd1, 4'd0, 0, 0, 0};
      vecs[10] = '{0, 0, 1, 0, 8'd1, 4'd0, 0, 0, 0};
      vecs[11] = '{1, 0, 0, 1, 8'd0, 4'd0, 0, 1, 0};
      vecs[12] = '{0, 0, 0, 1, 8'd0, 4'd0, 0, 1, 1};
      vecs[13] = '{0, 0, 0, 1, 8'd0, 4'd0, 0, 1, 1};
      vecs[14] = '{0, 1, 0, 1, 8'd0, 4'd0, 0, 0, 0};

      reset_n = 1'b0; start = 0; stop = 0; pause = 0; mode = 0; limit = 0; prescale = 0;
      modelReset();
      #3;
      checkOutput("resetState", 0, 0, 0);
      #9 reset_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].st, vecs[i].sp, vecs[i].pa, vecs[i].md, vecs[i].lim, vecs[i].pre);
         checkOutput($sformatf("vec%0d", i), vecs[i].eQ, vecs[i].eB, vecs[i].eD);
      end

      // Periodic, limit 2, prescale 1; limit input changes mid-run
      applyStimulus(1, 0, 0, 1, 8'd2, 4'd1);
      checkModel("periodicStart");
      doneCount = 0;
      for (int i = 0; i < 18; i++) begin
         applyStimulus(0, 0, 0, 1, (i >= 5) ? 8'd7 : 8'd2, 4'd1);
         checkModel($sformatf("periodic%0d", i));
         if (done) doneCount++;
      end
      checks++;
      if (doneCount != 3) begin
         errors++;
         $display("[TB] FAIL periodicDoneCount: got %0d, expected 3", doneCount);
      end
      applyStimulus(0, 1, 0, 0, 8'd0, 4'd0);
      checkOutput("periodicStop", 0, 0, 0);

      // Pause at Q=4, hold, resume
      applyStimulus(1, 0, 0, 0, 8'd9, 4'd0);
      reached = 0;
      for (int i = 0; i < 20 && !reached; i++) begin
         applyStimulus(0, 0, 0, 0, 8'd9, 4'd0);
         if (Q == 8'd4) reached = 1;
      end
      checkOutput("reachQ4", 4, 1, 0);
      applyStimulus(0, 0, 1, 0, 8'd9, 4'd0);
      checkOutput("pauseEnter", 4, 1, 0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 0, 0, 0, 8'd9, 4'd0);
         checkOutput($sformatf("pauseHold%0d", i), 4, 1, 0);
      end
      applyStimulus(1, 0, 0, 0, 8'd9, 4'd0);
      checkOutput("resumeEdge", 4, 1, 0);
      applyStimulus(0, 0, 0, 0, 8'd9, 4'd0);
      checkOutput("resumeCount", 5, 1, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 8'd9, 4'd0);
      checkOutput("reachQ9", 9, 1, 0);
      applyStimulus(0, 0, 0, 0, 8'd9, 4'd0);
      checkOutput("pauseRunDone", 9, 0, 1);

      // Stop and start together in RUN
      applyStimulus(1, 0, 0, 0, 8'd5, 4'd0);
      applyStimulus(0, 0, 0, 0, 8'd5, 4'd0);
      applyStimulus(1, 1, 0, 0, 8'd5, 4'd0);
      checkOutput("stopStartRun", 0, 0, 0);

      // Stop on the terminal tick
      applyStimulus(1, 0, 0, 0, 8'd2, 4'd0);
      applyStimulus(0, 0, 0, 0, 8'd2, 4'd0);
      applyStimulus(0, 0, 0, 0, 8'd2, 4'd0);
      checkOutput("stopTermPre", 2, 1, 0);
      applyStimulus(0, 1, 0, 0, 8'd2, 4'd0);
      checkOutput("stopOnTerminal", 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 8'd2, 4'd0);
      checkOutput("stopOnTerminalAfter", 0, 0, 0);

      // Pause on the terminal tick, then resume
      applyStimulus(1, 0, 0, 0, 8'd2, 4'd0);
      applyStimulus(0, 0, 0, 0, 8'd2, 4'd0);
      applyStimulus(0, 0, 0, 0, 8'd2, 4'd0);
      applyStimulus(0, 0, 1, 0, 8'd2, 4'd0);
      checkOutput("pauseOnTerminal", 2, 1, 0);
      applyStimulus(0, 0, 0, 0, 8'd2, 4'd0);
      checkOutput("pauseOnTerminalHold", 2, 1, 0);
      applyStimulus(1, 0, 0, 0, 8'd2, 4'd0);
      checkOutput("pauseTermResume", 2, 1, 0);
      applyStimulus(0, 0, 0, 0, 8'd2, 4'd0);
      checkOutput("pauseTermDone", 2, 0, 1);

      // Full range, limit 255 periodic
      applyStimulus(1, 0, 0, 1, 8'd255, 4'd0);
      for (int i = 0; i < 255; i++) begin
         applyStimulus(0, 0, 0, 1, 8'd255, 4'd0);
         checkModel($sformatf("full%0d", i));
      end
      checkOutput("fullReach255", 255, 1, 0);
      applyStimulus(0, 0, 0, 1, 8'd255, 4'd0);
      checkOutput("fullWrap", 0, 1, 1);
      applyStimulus(0, 1, 0, 0, 8'd0, 4'd0);

      // Asynchronous reset mid-run at Q=5
      applyStimulus(1, 0, 0, 0, 8'd9, 4'd0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 8'd9, 4'd0);
      checkOutput("preResetQ5", 5, 1, 0);
      #2 reset_n = 1'b0;
      modelReset();
      #1;
      checkOutput("asyncReset", 0, 0, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Randomized commands against the model
      for (int i = 0; i < 2000; i++) begin
         bit st, sp, pa, md;
         logic [7:0] lim;
         logic [3:0] pre;
         st  = ($urandom_range(0, 99) < 10);
         sp  = ($urandom_range(0, 99) < 3);
         pa  = ($urandom_range(0, 99) < 6);
         md  = 1'($urandom_range(0, 1));
         lim = 8'($urandom_range(0, 6));
         pre = 4'($urandom_range(0, 3));
         applyStimulus(st, sp, pa, md, lim, pre);
         checkModel($sformatf("rand%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Timer/sequencer controller wrapped around an N-bit synchronous up-counter datapath.
- Accepts start/stop/pause commands, a programmable terminal count (limit), a clock prescaler and a one-shot/periodic mode.
- Drives the counter's clear/enable and reports busy/done status.
- Sits between the control logic or register interface and the counter datapath; the counter value is exported as Q.

Parameters:
- N, 8, counter width in bits.
- PRESCALE_W, 4, width of the prescale field; counter advances once every prescale+1 clocks.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle command: begin a run from IDLE/DONE, or resume from PAUSE.
- stop  input  1  single-cycle command: abort and return to IDLE.
- pause  input  1  single-cycle command: freeze the count while in RUN.
- mode  input  1  0 = one-shot, 1 = periodic; sampled only when start is accepted from IDLE/DONE.
- limit  input  N  terminal count value; sampled with mode.
- prescale  input  PRESCALE_W  tick divider; sampled with mode.
- Q  output  N  current count.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  one-cycle pulse on each terminal event.

Behaviour:
- Reset (asynchronous, any time, including mid-run): state=IDLE, Q=0, busy=0, done=0, prescale counter=0, latched config=0.
- States: IDLE, RUN, PAUSE, DONE. busy = (RUN or PAUSE). All outputs are registered.
- Command priority on the same edge: stop > start > pause.
- IDLE:
  - start -> RUN; latch mode/limit/prescale; Q<=0; prescale counter<=0.
  - stop and pause are ignored.
- RUN:
  - The prescale counter increments every clock.
  - A tick occurs on the edge where prescale counter == latched prescale; on that edge the prescale counter returns to 0.
  - On a tick with Q != limit: Q<=Q+1.
  - On a tick with Q == limit (terminal event), done<=1 for exactly one cycle, and:
    - one-shot: -> DONE, Q holds limit.
    - periodic: Q<=0, stay in RUN.
  - A run therefore spans (limit+1)*(prescale+1) clocks per period.
  - Example, prescale=0, limit=3: start accepted at edge E0 gives Q=0; E1, E2, E3 give Q=1, 2, 3; at E4 done=1 and Q holds 3 (one-shot) or returns to 0 (periodic).
  - pause -> PAUSE; Q and the prescale counter freeze. A tick coinciding with pause is suppressed: no increment, no done.
  - stop -> IDLE, Q<=0, no done pulse even if a terminal tick coincides.
  - start is ignored.
- PAUSE:
  - start -> RUN, resuming with Q and the prescale counter unchanged and config not re-latched.
  - stop -> IDLE, Q<=0.
  - pause is ignored.
- DONE:
  - busy=0; Q holds limit.
  - start -> RUN with a fresh latch of config, Q<=0.
  - stop -> IDLE, Q<=0.
- Boundary cases:
  - limit=0: Q stays 0; done pulses every prescale+1 clocks (periodic) or once (one-shot).
  - limit=2^N-1: full range; Q never overflows because the counter wraps at limit, not at 2^N.
  - Changes on mode/limit/prescale while busy have no effect until the next start accepted from IDLE/DONE.
- Arithmetic: unsigned; limit compare is an equality compare against Q.

Decomposition:
- Package counter_sequencer_pkg holds:
  - 2-bit state typedef with encodings IDLE=0, RUN=1, PAUSE=2, DONE=3.
  - Constants MODE_ONESHOT=0 and MODE_PERIODIC=1.
- One sub-module, syn_up_counter_ce: parameter N; ports clk, reset_n, clr, en, Q. It is a synchronous clear plus enable up-counter; the sequencer drives clr/en.
- The prescaler, FSM and compare logic stay in the top module.

Test Plan:
- Reset: assert reset_n=0 mid-RUN with Q=5 -> Q=0, busy=0, done=0 immediately, without waiting for a clock edge.
- One-shot, limit=3, prescale=0, start pulse: Q=0,1,2,3 on consecutive cycles; done=1 for one cycle on the 5th edge; state DONE, Q holds 3, busy=0.
- Periodic, limit=2, prescale=1:
  - Q changes every 2 clocks through 0,1,2,0,...
  - done pulses every 6 clocks.
  - Changing limit to 7 mid-run has no effect.
- Pause/resume, one-shot, limit=9: pause at Q=4 -> Q holds 4 for 10 cycles with busy=1; start -> counting resumes at 5; done fires after Q=9.
- Collisions:
  - stop and start asserted together while in RUN -> IDLE, Q=0.
  - stop on the terminal tick -> no done pulse.
  - pause on the terminal tick -> no done; done occurs after resume.
- Edge configs:
  - limit=0, prescale=0, periodic -> done high every cycle, Q=0.
  - limit=255 with N=8 -> Q reaches 255, then done pulses and Q returns to 0.
